pid_sequencer: RTL and testbench

PID_SEQUENCER -- requirements
Module: pid_sequencer

---
 rtl/pid_sequencer_pkg.sv | 31 +++
 rtl/pid_sequencer_shift_add_mult.sv | 56 +++++
 rtl/pid_sequencer.sv | 151 +++++++++++++++
 tb/tb_pid_sequencer.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/pid_sequencer_pkg.sv
// Shared widths, saturation limits, state encoding and the output
// saturation helper for the PID sequencer.
package pid_sequencer_pkg;

   localparam int E_W        = 6;
   localparam int K_W        = 6;
   localparam int OP_W       = 8;
   localparam int PROD_W     = 14;
   localparam int SUM_W      = 16;
   localparam int U_W        = 8;
   localparam int DIFF_W     = 7;
   localparam int MUL_CYCLES = 6;

   localparam logic signed [SUM_W-1:0] SAT_HI = 16'sd127;
   localparam logic signed [SUM_W-1:0] SAT_LO = -16'sd128;

   typedef enum logic [2:0] {
      IDLE, LOAD, MUL_P, MUL_I, MUL_D, SUM
   } state_t;

   // Clamp a 16-bit signed value into the 8-bit signed range.
   function automatic logic signed [U_W-1:0] sat_u(input logic signed [SUM_W-1:0] x);
      if (x > SAT_HI)
         return SAT_HI[U_W-1:0];
      else if (x < SAT_LO)
         return SAT_LO[U_W-1:0];
      else
         return x[U_W-1:0];
   endfunction

endpackage

// File: rtl/pid_sequencer_shift_add_mult.sv
// Shared shift-add multiplier: one gain bit per cycle, LSB first, with
// 14-bit signed accumulation of the sign-extended operand.
module pid_shift_add_mult
   import pid_sequencer_pkg::*;
(
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start,
   input  logic signed [OP_W-1:0]   op,
   input  logic        [K_W-1:0]    k,
   output logic signed [PROD_W-1:0] product,
   output logic                     done
);

   logic signed [OP_W-1:0] op_r;
   logic        [K_W-1:0]  k_r;
   logic        [2:0]      bit_idx;
   logic                   running;

   function automatic logic signed [PROD_W-1:0] sext_op(input logic signed [OP_W-1:0] x);
      return {{(PROD_W-OP_W){x[OP_W-1]}}, x};
   endfunction

   // Bit 0 is consumed on the start edge, bits 1..5 on the following
   // five edges, so the exact product is present six edges after start.
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values, regardless of statement order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         op_r    <= '0;
         k_r     <= '0;
         bit_idx <= '0;
         running <= 1'b0;
         product <= '0;
         done    <= 1'b0;
      end else if (start) begin
         op_r    <= op;
         k_r     <= k;
         product <= k[0] ? sext_op(op) : '0;
         bit_idx <= 3'd1;
         running <= 1'b1;
         done    <= 1'b0;
      end else if (running) begin
         if (k_r[bit_idx])
            product <= product + (sext_op(op_r) <<< bit_idx);
         if (bit_idx == 3'(K_W-1)) begin
            running <= 1'b0;
            done    <= 1'b1;
         end
         bit_idx <= bit_idx + 3'd1;
      end else begin
         done <= 1'b0;
      end
   end

endmodule

// File: rtl/pid_sequencer.sv
// PID evaluation sequencer: latches a sample, updates integrator and
// difference, runs three products on one shift-add multiplier, saturates u.
module pid_sequencer
   import pid_sequencer_pkg::*;
#(
   parameter int OUT_SHIFT = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  ena,
   input  logic        [E_W-1:0] e,
   input  logic        [K_W-1:0] K_p,
   input  logic        [K_W-1:0] K_i,
   input  logic        [K_W-1:0] K_d,
   output logic signed [U_W-1:0] u,
   output logic                  u_valid,
   output logic                  busy,
   output logic                  overrun
);

   state_t                   state;
   logic signed [E_W-1:0]    e_r;
   logic        [K_W-1:0]    kp_r, ki_r, kd_r;
   logic signed [DIFF_W-1:0] diff_r;
   logic signed [E_W-1:0]    e_prior;
   logic signed [OP_W-1:0]   integ;
   logic        [2:0]        mul_cnt;
   logic signed [PROD_W-1:0] prod_p, prod_i;

   logic signed [OP_W-1:0]   mul_op;
   logic        [K_W-1:0]    mul_k;
   logic                     mul_start;
   logic signed [PROD_W-1:0] mul_product;
   logic                     mul_done;

   logic signed [E_W-1:0]    e_s;
   logic signed [DIFF_W-1:0] diff_next;
   logic signed [SUM_W-1:0]  integ_sum;
   logic signed [SUM_W-1:0]  pid_sum;
   logic signed [SUM_W-1:0]  pid_shifted;

   // Both operands are widened by one bit first, so e - e_prior cannot wrap.
   assign e_s         = $signed(e);
   assign diff_next   = {e_s[E_W-1], e_s} - {e_prior[E_W-1], e_prior};
   assign integ_sum   = {{(SUM_W-OP_W){integ[OP_W-1]}}, integ}
                      + {{(SUM_W-E_W){e_s[E_W-1]}}, e_s};
   assign pid_sum     = {{(SUM_W-PROD_W){prod_p[PROD_W-1]}}, prod_p}
                      + {{(SUM_W-PROD_W){prod_i[PROD_W-1]}}, prod_i}
                      + {{(SUM_W-PROD_W){mul_product[PROD_W-1]}}, mul_product};
   assign pid_shifted = pid_sum >>> OUT_SHIFT;

   assign mul_start = (state == MUL_P || state == MUL_I || state == MUL_D)
                      && (mul_cnt == 3'd0);

   // NOTE: every output of a combinational block gets a default first, so no
   // path through the case statement can leave a latch behind.
   always_comb begin
      mul_op = '0;
      mul_k  = '0;
      case (state)
         MUL_P: begin
            mul_op = {{(OP_W-E_W){e_r[E_W-1]}}, e_r};
            mul_k  = kp_r;
         end
         MUL_I: begin
            mul_op = integ;
            mul_k  = ki_r;
         end
         MUL_D: begin
            mul_op = {{(OP_W-DIFF_W){diff_r[DIFF_W-1]}}, diff_r};
            mul_k  = kd_r;
         end
         default: ;
      endcase
   end

   pid_shift_add_mult u_mult (
      .clk     (clk),
      .rst     (rst),
      .start   (mul_start),
      .op      (mul_op),
      .k       (mul_k),
      .product (mul_product),
      .done    (mul_done)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         e_r     <= '0;
         kp_r    <= '0;
         ki_r    <= '0;
         kd_r    <= '0;
         diff_r  <= '0;
         e_prior <= '0;
         integ   <= '0;
         mul_cnt <= '0;
         prod_p  <= '0;
         prod_i  <= '0;
         u       <= '0;
         u_valid <= 1'b0;
         busy    <= 1'b0;
         overrun <= 1'b0;
      end else begin
         u_valid <= 1'b0;
         overrun <= (state != IDLE) && ena;
         case (state)
            IDLE: begin
               if (ena) begin
                  state <= LOAD;
                  busy  <= 1'b1;
               end
            end
            LOAD: begin
               e_r     <= e_s;
               kp_r    <= K_p;
               ki_r    <= K_i;
               kd_r    <= K_d;
               diff_r  <= diff_next;
               e_prior <= e_s;
               integ   <= sat_u(integ_sum);
               mul_cnt <= '0;
               state   <= MUL_P;
            end
            MUL_P, MUL_I, MUL_D: begin
               // The previous product is complete during the first cycle of the next phase.
               if (mul_done && state == MUL_I) prod_p <= mul_product;
               if (mul_done && state == MUL_D) prod_i <= mul_product;
               if (mul_cnt == 3'(MUL_CYCLES-1)) begin
                  mul_cnt <= '0;
                  case (state)
                     MUL_P:   state <= MUL_I;
                     MUL_I:   state <= MUL_D;
                     default: state <= SUM;
                  endcase
               end else begin
                  mul_cnt <= mul_cnt + 3'd1;
               end
            end
            SUM: begin
               u       <= sat_u(pid_shifted);
               u_valid <= 1'b1;
               busy    <= 1'b0;
               state   <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_pid_sequencer.sv
// Scoreboard bench for pid_sequencer: an arithmetic PID model predicts each
// result and its arrival time; a negedge monitor compares what the DUT shows.
module tb_pid_sequencer;

   localparam int OUT_SHIFT = 2;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              ena = 1'b0;
   logic        [5:0] e   = '0;
   logic        [5:0] K_p = '0, K_i = '0, K_d = '0;
   logic signed [7:0] u;
   logic              u_valid, busy, overrun;

   int     total = 0;
   int     bad   = 0;
   int     exp_u_q[$];
   longint exp_t_q[$];
   int     m_prior = 0, m_integ = 0;
   int     last_u = 0, got_u = 0;
   int     ov_cnt = 0, busy_cnt = 0, valid_cnt = 0;

   always #5 clk = ~clk;

   pid_sequencer #(.OUT_SHIFT(OUT_SHIFT)) dut (
      .clk     (clk),
      .rst     (rst),
      .ena     (ena),
      .e       (e),
      .K_p     (K_p),
      .K_i     (K_i),
      .K_d     (K_d),
      .u       (u),
      .u_valid (u_valid),
      .busy    (busy),
      .overrun (overrun)
   );

   task automatic check(input string name, input longint got, input longint want);
      total++;
      if (got != want) begin
         bad++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, want, $time);
      end
   endtask

   function automatic int clamp(input int x, input int lo, input int hi);
      return (x > hi) ? hi : (x < lo) ? lo : x;
   endfunction

   // Arithmetic PID reference: one call per accepted sample.
   function automatic int model_eval(input int es, input int kp, input int ki, input int kd);
      int diff, sum;
      diff    = es - m_prior;
      m_prior = es;
      m_integ = clamp(m_integ + es, -128, 127);
      sum     = kp * es + ki * m_integ + kd * diff;
      return clamp(sum >>> OUT_SHIFT, -128, 127);
   endfunction

   // Monitor: compares results, latency and hold behaviour on every negedge.
   always @(negedge clk) begin
      if (!rst) begin
         if (overrun) ov_cnt++;
         if (busy) busy_cnt++;
         if (u_valid) begin
            valid_cnt++;
            if (exp_u_q.size() == 0) begin
               check("spurious_u_valid", 1, 0);
            end else begin
               check("u_result", int'(u), exp_u_q.pop_front());
               check("latency_time", longint'($time), exp_t_q.pop_front());
            end
            last_u = u;
            got_u  = u;
         end else begin
            check("u_hold", int'(u), last_u);
         end
      end
   end

   // Driver tasks are entered and left just after a falling edge.
   task automatic issue(input logic [5:0] ev, input logic [5:0] kp,
                        input logic [5:0] ki, input logic [5:0] kd);
      logic signed [5:0] es;
      es  = ev;
      ena = 1'b1;
      e   = ev;
      K_p = kp;
      K_i = ki;
      K_d = kd;
      exp_u_q.push_back(model_eval(es, kp, ki, kd));
      exp_t_q.push_back(longint'($time) + 209);
      @(negedge clk); #1;
      ena = 1'b0;
      @(negedge clk); #1;
      e   = 6'($urandom);
      K_p = 6'($urandom);
      K_i = 6'($urandom);
      K_d = 6'($urandom);
   endtask

   task automatic wait_done();
      for (int i = 0; i < 40; i++) begin
         if (exp_u_q.size() == 0) return;
         @(negedge clk); #1;
      end
      check("result_timeout", exp_u_q.size(), 0);
      exp_u_q.delete();
      exp_t_q.delete();
   endtask

   task automatic reset_dut();
      #1;
      rst = 1'b1;
      #1;
      check("rst_u", int'(u), 0);
      check("rst_u_valid", u_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_overrun", overrun, 0);
      exp_u_q.delete();
      exp_t_q.delete();
      m_prior = 0;
      m_integ = 0;
      last_u  = 0;
      @(negedge clk); #1;
      rst = 1'b0;
   endtask

   initial begin
      int integ_u[5] = '{7, 15, 23, 31, 31};
      int ov0, v0;

      @(negedge clk); #1;
      reset_dut();

      // Proportional only, with busy duration.
      busy_cnt = 0;
      issue(6'd4, 6'd3, 6'd0, 6'd0);
      wait_done();
      check("p_only_u", got_u, 3);
      check("busy_cycles", busy_cnt, 20);

      // Derivative: first sample sees diff 10, repeat sees diff 0.
      reset_dut();
      issue(6'd10, 6'd0, 6'd0, 6'd2);
      wait_done();
      check("d_first_u", got_u, 5);
      issue(6'd10, 6'd0, 6'd0, 6'd2);
      wait_done();
      check("d_repeat_u", got_u, 0);

      // Integrator ramps and saturates at +127.
      reset_dut();
      for (int i = 0; i < 5; i++) begin
         issue(6'd31, 6'd0, 6'd1, 6'd0);
         wait_done();
         check($sformatf("integ_step%0d_u", i), got_u, integ_u[i]);
      end

      // Output saturation at both limits.
      issue(6'd31, 6'd63, 6'd0, 6'd0);
      wait_done();
      check("sat_pos_u", got_u, 127);
      issue(6'h20, 6'd63, 6'd0, 6'd0);
      wait_done();
      check("sat_neg_u", got_u, -128);

      // ena five cycles into an evaluation only raises overrun.
      ov0 = ov_cnt;
      v0  = valid_cnt;
      issue(6'd7, 6'd5, 6'd2, 6'd3);
      repeat (3) begin @(negedge clk); #1; end
      ena = 1'b1;
      e   = 6'h2b;
      @(negedge clk); #1;
      ena = 1'b0;
      wait_done();
      repeat (3) begin @(negedge clk); #1; end
      check("overrun_pulses", ov_cnt - ov0, 1);
      check("overrun_valid_count", valid_cnt - v0, 1);

      // Reset during MUL_I aborts the evaluation and clears history.
      reset_dut();
      issue(6'd20, 6'd10, 6'd10, 6'd10);
      repeat (8) begin @(negedge clk); #1; end
      v0 = valid_cnt;
      reset_dut();
      repeat (25) begin @(negedge clk); #1; end
      check("abort_no_valid", valid_cnt - v0, 0);
      issue(6'd5, 6'd0, 6'd1, 6'd1);
      wait_done();
      check("post_reset_u", got_u, 2);

      // Randomized evaluations, including back-to-back starts.
      ov0 = ov_cnt;
      for (int n = 0; n < 40; n++) begin
         repeat ($urandom_range(0, 3)) begin @(negedge clk); #1; end
         issue(6'($urandom), 6'($urandom), 6'($urandom), 6'($urandom));
         wait_done();
      end
      check("random_no_overrun", ov_cnt - ov0, 0);

      repeat (3) begin @(negedge clk); #1; end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
